win_cmd_gen: RTL and testbench
==============================

# win_cmd_gen

Front-end stage that turns raw board push-buttons into the `WIN_CTRL_CMD` bus consumed by `cursor_ctrl`. Per button: synchronises, debounces and cancels opposing presses. Direction buttons get hold-to-auto-repeat by re-arming a rising edge, because the consumer acts only on rising edges. A mode button toggles the `M_MODE` bit, which selects whether a move applies to the window or to the cursor.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronised cycles required before a debounced level changes; legal range ≥1.
- `REPEAT_DELAY`, default 25000000: cycles a direction must be held before the first repeat gap; 0 disables auto-repeat.
- `REPEAT_PERIOD`, default 5000000: cycles between successive repeat gaps; must be ≥2.
- `CNT_W`, default 26: width of the debounce and repeat counters; must hold `max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)`.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: reset, synchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each: raw direction buttons, active-high, asynchronous.
- `btn_zin`, `btn_zout`  in  1 each: raw zoom buttons, active-high, asynchronous.
- `btn_mode`  in  1: raw move-mode toggle button, active-high, asynchronous.
- `win_ctrl_cmd`  out  `WIN_CTRL_CMD`: registered command bus.
  - Bits are placed at `M_UP`, `M_DOWN`, `M_LEFT`, `M_RIGHT`, `Z_IN`, `Z_OUT`, `M_MODE`.
  - Any other bits are driven 0.

## Operation
Synchroniser
- Each raw button passes through a 2-flop synchroniser, giving signal `s`.

Debouncer (one per button)
- Holds a debounced level `db` and a counter.
- When `s == db`: counter clears.
- When `s != db`: counter increments.
- When the counter reaches `DEBOUNCE_CYCLES-1` and `s != db` still holds: `db <= s` and the counter clears.

Opposing-pair cancel
- `up`/`down` and `left`/`right` are cancelling pairs.
- If both members' `db` are 1, both effective levels are 0.
- When one member is released, the other becomes effective immediately and is treated as a new press.

Direction channel FSM, one per direction; states IDLE, HELD, GAP:
- IDLE: output 0. On effective `db` = 1, go to HELD, output 1, repeat counter = 0.
- HELD: output 1, counter increments each cycle.
  - If `REPEAT_DELAY != 0` and the counter reaches the threshold, go to GAP.
  - The threshold is `REPEAT_DELAY-1` for the first gap after a press and `REPEAT_PERIOD-2` afterwards.
- GAP: output 0 for exactly one cycle. Return to HELD with counter = 0 and the repeat flag set.
- In any state, effective `db` = 0 goes to IDLE and output 0 on the next cycle.

Zoom bits
- Registered copy of effective `db` (no cancel pairing between `zin` and `zout`; no repeat).

Mode bit
- On each rising edge of `db` for `btn_mode`, the `M_MODE` register toggles.
- 0 = cursor move, 1 = window move.
- Holding the mode button does not repeat the toggle.

Reset
- `rst` = 1 on a clock edge: all synchronisers, `db` levels, counters and outputs clear to 0; all FSMs go to IDLE; `M_MODE` = 0.
- Reset asserted mid-press: the press is lost. A button still held after reset is seen as a fresh press once debounced.

## Timing
- Press latency: a raw transition sampled at edge k shows on the output bit at edge k + `DEBOUNCE_CYCLES` + 3.
  - 2 cycles synchroniser, `DEBOUNCE_CYCLES` cycles debounce, 1 cycle output register.
- Release latency is the same.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles never reach any output.
- Repeat pattern for a press whose output rises at cycle T:
  - gaps (output 0) at T+`REPEAT_DELAY`;
  - then every `REPEAT_PERIOD` cycles: T+`REPEAT_DELAY`+n·`REPEAT_PERIOD`.
- Each gap is followed by a rising edge one cycle later.
- `M_MODE` changes one cycle after `db` of the mode button rises.
- Channels are independent. Simultaneous presses of non-opposing buttons (e.g. up+right, or direction+mode) all appear on the same cycle.

## Test plan
Every scenario uses `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5.
- Reset: hold `rst` for 3 cycles with all buttons high, then release -> `win_ctrl_cmd` = 0 during reset; `M_UP` rises exactly 7 cycles after the first post-reset edge; `M_MODE` then toggles to 1 once.
- Bounce: `btn_left` toggles every 2 cycles for 20 cycles, then stays high -> `M_LEFT` stays 0 throughout the bounce, then rises 7 cycles after the last transition.
- Auto-repeat: hold `btn_right` so that `M_RIGHT` rises at T -> `M_RIGHT` is 0 only at T+10, T+15, T+20, …; release drops it 7 cycles after the raw fall, with no further gaps.
- Cancel: hold `up` steady, press `down` -> both bits 0 once `down` has debounced; release `down` -> `M_UP` rises again and the repeat timing restarts from that rise.
- Mode: press `btn_mode` 3 times, each press 20 cycles with 20-cycle gaps -> `M_MODE` sequence 0→1→0→1; holding for 100 cycles yields a single toggle.
- Zoom: hold `btn_zin` for 50 cycles -> `Z_IN` high continuously for 50 cycles with no gaps, delayed 7 cycles from the raw input.

Source files
------------

// File: rtl/win_cmd_gen.sv
// win_cmd_gen -- push-button front end for the cursor_ctrl command bus.
//
// Every raw button is synchronised (2 flops) and debounced. up/down and
// left/right cancel each other while both are held. Direction channels
// auto-repeat while held by inserting a one-cycle low gap, so the consumer
// sees a fresh rising edge. Zoom bits follow their debounced level. The mode
// button toggles M_MODE once per debounced press.
//
// Ports
//   clk                 system clock
//   rst                 synchronous, active-high reset
//   btn_up/down/left/right, btn_zin, btn_zout, btn_mode
//                       raw asynchronous buttons, active-high
//   win_ctrl_cmd        registered command bus:
//                       [0] M_UP [1] M_DOWN [2] M_LEFT [3] M_RIGHT
//                       [4] Z_IN [5] Z_OUT  [6] M_MODE [7] always 0
//
// A raw edge sampled at clock edge k reaches the bus at k + DEBOUNCE_CYCLES + 3
// for every bit, so simultaneous presses of independent buttons stay aligned.
//
// Direction channel FSM
//   state | meaning
//   IDLE  | effective level low, output low
//   HELD  | output high, repeat counter running
//   GAP   | one-cycle low pulse that re-arms the consumer's edge detector
module win_cmd_gen #(
   parameter  int unsigned DEBOUNCE_CYCLES = 500000,
   parameter  int unsigned REPEAT_DELAY    = 25000000,
   parameter  int unsigned REPEAT_PERIOD   = 5000000,
   parameter  int unsigned CNT_W           = 26,
   localparam int unsigned CMD_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic             btn_zin,
   input  logic             btn_zout,
   input  logic             btn_mode,
   output logic [CMD_W-1:0] win_ctrl_cmd
);

   localparam int unsigned M_UP    = 0;
   localparam int unsigned M_DOWN  = 1;
   localparam int unsigned M_LEFT  = 2;
   localparam int unsigned M_RIGHT = 3;
   localparam int unsigned Z_IN    = 4;
   localparam int unsigned Z_OUT   = 5;
   localparam int unsigned M_MODE  = 6;
   localparam int unsigned NBTN    = 7;
   localparam int unsigned NDIR    = 4;

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 2);
   localparam bit               RPT_EN      = (REPEAT_DELAY != 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HELD = 2'd1,
      S_GAP  = 2'd2
   } dir_state_t;

   // raw button vector, indexed like the command bus
   logic [NBTN-1:0] raw;
   assign raw = {btn_mode, btn_zout, btn_zin, btn_right, btn_left, btn_down, btn_up};

   // synchroniser
   logic [NBTN-1:0] sync_a;
   logic [NBTN-1:0] sync_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= '0;
         sync_s <= '0;
      end else begin
         sync_a <= raw;
         sync_s <= sync_a;
      end
   end

   // debouncers
   logic [NBTN-1:0]  db;
   logic [CNT_W-1:0] db_cnt [NBTN];

   always_ff @(posedge clk) begin
      if (rst) begin
         db <= '0;
         for (int i = 0; i < NBTN; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NBTN; i++) begin
            if (sync_s[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db[i]     <= sync_s[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   // opposing-pair cancel; releasing one member lets the other through at once
   logic [NDIR-1:0] dir_eff;
   assign dir_eff[M_UP]    = db[M_UP]    & ~db[M_DOWN];
   assign dir_eff[M_DOWN]  = db[M_DOWN]  & ~db[M_UP];
   assign dir_eff[M_LEFT]  = db[M_LEFT]  & ~db[M_RIGHT];
   assign dir_eff[M_RIGHT] = db[M_RIGHT] & ~db[M_LEFT];

   // direction channel FSMs
   dir_state_t       state    [NDIR];
   dir_state_t       state_nx [NDIR];
   logic [CNT_W-1:0] rpt_cnt    [NDIR];
   logic [CNT_W-1:0] rpt_cnt_nx [NDIR];
   logic [NDIR-1:0]  rpt_flag;
   logic [NDIR-1:0]  rpt_flag_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         rpt_flag <= '0;
         for (int i = 0; i < NDIR; i++) begin
            state[i]   <= S_IDLE;
            rpt_cnt[i] <= '0;
         end
      end else begin
         rpt_flag <= rpt_flag_nx;
         for (int i = 0; i < NDIR; i++) begin
            state[i]   <= state_nx[i];
            rpt_cnt[i] <= rpt_cnt_nx[i];
         end
      end
   end

   always_comb begin
      rpt_flag_nx = rpt_flag;
      for (int i = 0; i < NDIR; i++) begin
         state_nx[i]   = state[i];
         rpt_cnt_nx[i] = rpt_cnt[i];
         if (!dir_eff[i]) begin
            state_nx[i]    = S_IDLE;
            rpt_cnt_nx[i]  = '0;
            rpt_flag_nx[i] = 1'b0;
         end else begin
            case (state[i])
               S_IDLE: begin
                  state_nx[i]    = S_HELD;
                  rpt_cnt_nx[i]  = '0;
                  rpt_flag_nx[i] = 1'b0;
               end
               S_HELD: begin
                  // first gap after the initial delay, later ones every period;
                  // the gap cycle itself is part of the period, hence PERIOD-2
                  if (RPT_EN && rpt_cnt[i] == (rpt_flag[i] ? PERIOD_LAST : DELAY_LAST)) begin
                     state_nx[i] = S_GAP;
                  end else if (RPT_EN) begin
                     rpt_cnt_nx[i] = rpt_cnt[i] + CNT_ONE;
                  end
               end
               S_GAP: begin
                  state_nx[i]    = S_HELD;
                  rpt_cnt_nx[i]  = '0;
                  rpt_flag_nx[i] = 1'b1;
               end
               default: begin
                  state_nx[i]   = S_IDLE;
                  rpt_cnt_nx[i] = '0;
               end
            endcase
         end
      end
   end

   // zoom levels and mode toggle, one stage deep like the direction FSMs
   logic [1:0] zoom_q;
   logic       mode_db_q;
   logic       mode_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         zoom_q    <= '0;
         mode_db_q <= 1'b0;
         mode_q    <= 1'b0;
      end else begin
         zoom_q    <= {db[Z_OUT], db[Z_IN]};
         mode_db_q <= db[M_MODE];
         if (db[M_MODE] && !mode_db_q) mode_q <= ~mode_q;
      end
   end

   // output register
   logic [CMD_W-1:0] cmd_nx;

   always_comb begin
      cmd_nx = '0;
      for (int i = 0; i < NDIR; i++) cmd_nx[i] = (state[i] == S_HELD);
      cmd_nx[Z_IN]   = zoom_q[0];
      cmd_nx[Z_OUT]  = zoom_q[1];
      cmd_nx[M_MODE] = mode_q;
   end

   always_ff @(posedge clk) begin
      if (rst) win_ctrl_cmd <= '0;
      else     win_ctrl_cmd <= cmd_nx;
   end

endmodule

// File: tb/tb_win_cmd_gen.sv
// Self-checking bench for win_cmd_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5. Each scenario plans its raw stimulus per cycle, pushes the
// expected bus value for each cycle into a scoreboard queue, then drives the
// stimulus and pops/compares as the cycles elapse.
// Timing convention: stimulus index j is sampled at edge base+j and its effect
// reaches the bus at edge base+j+7; the bus is sampled on the falling edge.
module tb_win_cmd_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] btn;
   logic [7:0] win_ctrl_cmd;

   typedef struct {
      int         at;
      logic [7:0] mask;
      logic [7:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   win_cmd_gen #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (5),
      .CNT_W          (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_up      (btn[0]),
      .btn_down    (btn[1]),
      .btn_left    (btn[2]),
      .btn_right   (btn[3]),
      .btn_zin     (btn[4]),
      .btn_zout    (btn[5]),
      .btn_mode    (btn[6]),
      .win_ctrl_cmd(win_ctrl_cmd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic do_reset();
      rst = 1'b1;
      btn = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // buttons held through reset; down/left stay low since they would cancel
   task automatic test_reset();
      exp_t       e;
      int         base;
      logic [7:0] v;
      logic [7:0] m;
      rst  = 1'b1;
      btn  = 7'b1111001;
      base = cyc + 1;
      for (int j = 0; j < 3; j++) sb_q.push_back('{base + j, 8'hFF, 8'h00});
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (e.at != cyc || (win_ctrl_cmd & e.mask) !== e.val) begin
               n_err++;
               $display("FAIL reset_hold cyc=%0d got=%h exp=%h mask=%h", cyc, win_ctrl_cmd, e.val, e.mask);
            end
         end
      end
      rst  = 1'b0;
      base = cyc + 1;
      for (int j = 0; j < 25; j++) begin
         if (j < 7)       begin m = 8'hFF; v = 8'h00; end
         else if (j < 17) begin m = 8'hFF; v = 8'h79; end
         else             begin m = 8'h40; v = 8'h40; end
         sb_q.push_back('{base + j, m, v});
      end
      for (int j = 0; j < 25; j++) begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (e.at != cyc || (win_ctrl_cmd & e.mask) !== e.val) begin
               n_err++;
               $display("FAIL reset_release cyc=%0d got=%h exp=%h mask=%h", cyc, win_ctrl_cmd, e.val, e.mask);
            end
         end
      end
   endtask

   task automatic test_bounce();
      exp_t e;
      int   base;
      do_reset();
      base = cyc + 1;
      for (int j = 0; j < 36; j++) sb_q.push_back('{base + j, 8'hFF, (j >= 27) ? 8'h04 : 8'h00});
      for (int j = 0; j < 36; j++) begin
         btn    = '0;
         btn[2] = (j >= 20) ? 1'b1 : (((j / 2) % 2) == 0);
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (e.at != cyc || (win_ctrl_cmd & e.mask) !== e.val) begin
               n_err++;
               $display("FAIL bounce cyc=%0d got=%h exp=%h", cyc, win_ctrl_cmd, e.val);
            end
         end
      end
   endtask

   task automatic test_auto_repeat();
      exp_t       e;
      int         base;
      logic [7:0] v;
      do_reset();
      base = cyc + 1;
      // rises at 7; gaps at 17,22,27,32,37; raw release at 33 drops it at 40
      for (int j = 0; j < 51; j++) begin
         v = 8'h00;
         if (j >= 7 && j < 40 && !(j >= 17 && ((j - 17) % 5) == 0)) v = 8'h08;
         sb_q.push_back('{base + j, 8'hFF, v});
      end
      for (int j = 0; j < 51; j++) begin
         btn    = '0;
         btn[3] = (j < 33);
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (e.at != cyc || (win_ctrl_cmd & e.mask) !== e.val) begin
               n_err++;
               $display("FAIL auto_repeat cyc=%0d got=%h exp=%h", cyc, win_ctrl_cmd, e.val);
            end
         end
      end
   endtask

   task automatic test_cancel();
      exp_t       e;
      int         base;
      logic [7:0] v;
      do_reset();
      base = cyc + 1;
      // up from 0; down held 9..19 -> cancel from 16; up re-rises at 27, gaps 37,42
      for (int j = 0; j < 45; j++) begin
         v = 8'h00;
         if ((j >= 7 && j < 16) || (j >= 27 && j != 37 && j != 42)) v = 8'h01;
         sb_q.push_back('{base + j, 8'hFF, v});
      end
      for (int j = 0; j < 45; j++) begin
         btn    = '0;
         btn[0] = 1'b1;
         btn[1] = (j >= 9 && j < 20);
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (e.at != cyc || (win_ctrl_cmd & e.mask) !== e.val) begin
               n_err++;
               $display("FAIL cancel cyc=%0d got=%h exp=%h", cyc, win_ctrl_cmd, e.val);
            end
         end
      end
   endtask

   task automatic test_mode();
      exp_t e;
      int   base;
      int   toggles;
      do_reset();
      base = cyc + 1;
      // presses at 0,40,80 (20 cycles each) then a 100-cycle hold from 120
      for (int j = 0; j < 235; j++) begin
         toggles = 0;
         if (j >= 7)   toggles++;
         if (j >= 47)  toggles++;
         if (j >= 87)  toggles++;
         if (j >= 127) toggles++;
         sb_q.push_back('{base + j, 8'hFF, (toggles % 2 == 1) ? 8'h40 : 8'h00});
      end
      for (int j = 0; j < 235; j++) begin
         btn    = '0;
         btn[6] = (j < 20) || (j >= 40 && j < 60) || (j >= 80 && j < 100) || (j >= 120 && j < 220);
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (e.at != cyc || (win_ctrl_cmd & e.mask) !== e.val) begin
               n_err++;
               $display("FAIL mode cyc=%0d got=%h exp=%h", cyc, win_ctrl_cmd, e.val);
            end
         end
      end
   endtask

   task automatic test_zoom();
      exp_t e;
      int   base;
      do_reset();
      base = cyc + 1;
      for (int j = 0; j < 65; j++) sb_q.push_back('{base + j, 8'hFF, (j >= 7 && j < 57) ? 8'h10 : 8'h00});
      for (int j = 0; j < 65; j++) begin
         btn    = '0;
         btn[4] = (j < 50);
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (e.at != cyc || (win_ctrl_cmd & e.mask) !== e.val) begin
               n_err++;
               $display("FAIL zoom cyc=%0d got=%h exp=%h", cyc, win_ctrl_cmd, e.val);
            end
         end
      end
   endtask

   // up + right + zout + mode together must all land on the same cycle
   task automatic test_simultaneous();
      exp_t e;
      int   base;
      do_reset();
      base = cyc + 1;
      for (int j = 0; j < 17; j++) sb_q.push_back('{base + j, 8'hFF, (j >= 7) ? 8'h69 : 8'h00});
      for (int j = 0; j < 17; j++) begin
         btn = 7'b1101001;
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (e.at != cyc || (win_ctrl_cmd & e.mask) !== e.val) begin
               n_err++;
               $display("FAIL simultaneous cyc=%0d got=%h exp=%h", cyc, win_ctrl_cmd, e.val);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      btn = '0;
      test_reset();
      test_bounce();
      test_auto_repeat();
      test_cancel();
      test_mode();
      test_zoom();
      test_simultaneous();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
